systolic_input_skew: RTL and testbench

Feeder stage directly upstream of the PE array's left edge. Accepts one N-lane row vector per handshake from the activation buffer. Applies diagonal skew: lane i is delayed i extra cycles. Drives per-row datain and the active strobe into the array.
After the final vector it flushes zeros through the skew so the last diagonal reaches the array. Stalls by holding state and dropping active, which matches the PE hold-on-inactive semantics.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/skew_line.sv | 45 ++++
 rtl/systolic_input_skew.sv | 129 ++++++++++++
 tb/tb_systolic_input_skew.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: default geometry,
// feeder state encoding and a lane-slice helper.
package systolic_pkg;

    // Default array geometry, shared with the PE array.
    localparam int SYS_N     = 4;
    localparam int SYS_DW    = 8;
    localparam int SYS_LEN_W = 8;

    // Width of one lane slice in a packed row vector.
    localparam int LANE_W = SYS_DW;

    // Feeder sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

    // Low bit index of lane 'lane' in a packed vector of 'dw'-bit lanes.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/skew_line.sv
// One lane of the diagonal skew: a DEPTH-stage shift line that moves only
// on advance and otherwise holds every stage.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          advance,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] stage_q [DEPTH];
    logic [DW-1:0] stage_d [DEPTH];

    // Next stage values: load d into stage 0 and shift the rest on advance.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (advance) begin
            stage_d[0] = d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // Stage registers, cleared by the asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skew.sv
// Left-edge feeder for the PE array: accepts row vectors, skews lane i by
// i extra cycles, flushes zeros after the last vector and drives the
// array's active strobe.
module systolic_input_skew
    import systolic_pkg::*;
#(
    parameter int N     = SYS_N,
    parameter int DW    = SYS_DW,
    parameter int LEN_W = SYS_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  rows,
    input  logic              in_valid,
    input  logic [N*DW-1:0]   in_data,
    output logic              in_ready,
    output logic [N*DW-1:0]   out_data,
    output logic              out_active,
    output logic              busy,
    output logic              done
);

    // N-1 drain cycles must fit; keep at least one bit for N == 1.
    localparam int DC_W = (N > 1) ? $clog2(N) : 1;

    skew_state_t      state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic             out_active_q, out_active_d;
    logic             done_q, done_d;
    logic             advance;
    logic             shift_en;
    logic [N*DW-1:0]  inject;

    // Next-state, counter and advance decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        advance     = 1'b0;
        inject      = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (rows != '0) begin
                        remaining_d = rows;
                        state_d     = STREAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (in_valid) begin
                    advance     = 1'b1;
                    inject      = in_data;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        if (N > 1) begin
                            state_d     = DRAIN;
                            drain_cnt_d = DC_W'(N - 1);
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                advance     = 1'b1;
                drain_cnt_d = drain_cnt_q - DC_W'(1);
                if (drain_cnt_q == DC_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_active_d = advance;
    end

    // State, counters and registered strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            drain_cnt_q  <= '0;
            out_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            drain_cnt_q  <= drain_cnt_d;
            out_active_q <= out_active_d;
            done_q       <= done_d;
        end
    end

    // After the drain only the last stage of each lane can still hold data;
    // one extra zero shift in the done cycle (always IDLE, array inactive)
    // leaves every skew register at zero for the next tile.
    assign shift_en = advance | done_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            skew_line #(
                .DEPTH (gi + 1),
                .DW    (DW)
            ) u_line (
                .clock   (clock),
                .reset   (reset),
                .advance (shift_en),
                .d       (inject[lane_lo(gi, DW) +: DW]),
                .q       (out_data[lane_lo(gi, DW) +: DW])
            );
        end
    endgenerate

    assign in_ready   = (state_q == STREAM);
    assign busy       = (state_q != IDLE);
    assign out_active = out_active_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_input_skew.sv
// Directed bench for systolic_input_skew: a scoreboard of expected skewed
// vectors is filled when a tile is started and drained on every active cycle.
module tb_systolic_input_skew;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int LEN_W = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] rows;
    logic             in_valid;
    logic [N*DW-1:0]  in_data;
    logic             in_ready;
    logic [N*DW-1:0]  out_data;
    logic             out_active;
    logic             busy;
    logic             done;

    systolic_input_skew #(
        .N     (N),
        .DW    (DW),
        .LEN_W (LEN_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rows       (rows),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_active (out_active),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int cyc      = 0;
    bit last_done;
    int act_cyc[$];
    logic [N*DW-1:0] sb[$];
    logic [N*DW-1:0] tv[8];

    function automatic logic [N*DW-1:0] vec(input int a, input int b, input int c, input int d);
        logic [N*DW-1:0] v;
        v[0*DW +: DW] = DW'(a);
        v[1*DW +: DW] = DW'(b);
        v[2*DW +: DW] = DW'(c);
        v[3*DW +: DW] = DW'(d);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected output of a tile of n vectors from tv[]: lane i on active
    // cycle k carries vector k-i, or zero outside the tile.
    task automatic push_tile(input int n);
        logic [N*DW-1:0] v;
        for (int k = 0; k < n + N - 1; k++) begin
            v = '0;
            for (int i = 0; i < N; i++) begin
                int j;
                j = k - i;
                if (j >= 0 && j < n) v[i*DW +: DW] = tv[j][i*DW +: DW];
            end
            sb.push_back(v);
        end
    endtask

    task automatic monitor();
        logic [N*DW-1:0] exp_v;
        cyc++;
        last_done = 1'b0;
        if (!reset) begin
            if (out_active) begin
                act_cyc.push_back(cyc);
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_active: observed active at cycle %0d, expected inactive", cyc);
                end
                if (sb.size() > 0) begin
                    exp_v = sb.pop_front();
                    check("lane_data", 64'(out_data), 64'(exp_v));
                end
            end
            if (done) begin
                done_cnt++;
                last_done = 1'b1;
                check("done_with_last_active", sb.size(), 0);
            end
        end
    endtask

    // Sample outputs on the falling edge, then apply one rising edge.
    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (last_done) seen = 1'b1;
        end
        tests++;
        assert (seen) else begin
            fails++;
            $error("FAIL %s: observed no done within 40 cycles, expected done", tag);
        end
    endtask

    function automatic int span_since(input int n0);
        if (act_cyc.size() > n0) return act_cyc[act_cyc.size()-1] - act_cyc[n0] + 1;
        return 0;
    endfunction

    initial begin
        int n0;
        int d0;
        int l0;

        reset = 1'b1; start = 1'b0; rows = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_active", out_active, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        step();

        // Test 1: full tile, no stalls.
        tv[0] = vec(1, 2, 3, 4); tv[1] = vec(5, 6, 7, 8); tv[2] = vec(9, 10, 11, 12);
        push_tile(3);
        n0 = act_cyc.size(); d0 = done_cnt;
        start = 1'b1; rows = 8'd3; step(); start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data = tv[0]; step();
        in_data = tv[1]; step();
        in_data = tv[2]; step();
        in_valid = 1'b0; in_data = '0;
        wait_done("t1_done");
        check("t1_active_cnt", act_cyc.size() - n0, 6);
        check("t1_active_span", span_since(n0), 6);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_busy_after", busy, 0);
        check("t1_flushed", 64'(out_data), 64'(0));

        // Test 2: two stall cycles after the first accept.
        push_tile(3);
        n0 = act_cyc.size();
        start = 1'b1; rows = 8'd3; step(); start = 1'b0;
        in_valid = 1'b1; in_data = tv[0]; step();
        in_valid = 1'b0; in_data = vec(99, 99, 99, 99);
        step();
        check("t2_frozen_a", 64'(out_data), 64'(vec(1, 0, 0, 0)));
        check("t2_inactive_a", out_active, 0);
        step();
        check("t2_frozen_b", 64'(out_data), 64'(vec(1, 0, 0, 0)));
        check("t2_inactive_b", out_active, 0);
        in_valid = 1'b1;
        in_data = tv[1]; step();
        in_data = tv[2]; step();
        in_valid = 1'b0; in_data = '0;
        wait_done("t2_done");
        check("t2_active_cnt", act_cyc.size() - n0, 6);
        check("t2_active_span", span_since(n0), 8);

        // Test 3: zero-length tile.
        d0 = done_cnt; n0 = act_cyc.size();
        start = 1'b1; rows = 8'd0; step(); start = 1'b0;
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_in_ready", in_ready, 0);
        check("t3_out_active", out_active, 0);
        step();
        check("t3_done_low", done, 0);
        check("t3_done_cnt", done_cnt - d0, 1);
        check("t3_no_active", act_cyc.size() - n0, 0);

        // Test 4: start during DRAIN is ignored; in_valid outside STREAM too.
        tv[0] = vec(10, 20, 30, 40); tv[1] = vec(-5, 6, -7, 8);
        push_tile(2);
        n0 = act_cyc.size(); d0 = done_cnt;
        start = 1'b1; rows = 8'd2; step(); start = 1'b0;
        in_valid = 1'b1;
        in_data = tv[0]; step();
        in_data = tv[1]; step();
        in_data = vec(77, 77, 77, 77);
        check("t4_drain_in_ready", in_ready, 0);
        check("t4_drain_busy", busy, 1);
        start = 1'b1; rows = 8'd9; step(); start = 1'b0;
        wait_done("t4_done");
        in_valid = 1'b0;
        repeat (4) step();
        check("t4_active_cnt", act_cyc.size() - n0, 5);
        check("t4_done_cnt", done_cnt - d0, 1);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_in_ready", in_ready, 0);

        // Test 5: reset in the middle of STREAM.
        tv[0] = vec(1, 2, 3, 4);
        push_tile(3);
        start = 1'b1; rows = 8'd3; step(); start = 1'b0;
        in_valid = 1'b1; in_data = tv[0]; step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_out_data", 64'(out_data), 64'(0));
        check("t5_out_active", out_active, 0);
        check("t5_busy", busy, 0);
        sb.delete();
        d0 = done_cnt;
        step(); step();
        reset = 1'b0;
        step(); step();
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_idle_busy", busy, 0);
        tv[0] = vec(7, 7, 7, 7);
        push_tile(1);
        n0 = act_cyc.size();
        start = 1'b1; rows = 8'd1; step(); start = 1'b0;
        in_valid = 1'b1; in_data = tv[0]; step();
        in_valid = 1'b0; in_data = '0;
        wait_done("t5_done");
        check("t5_active_cnt", act_cyc.size() - n0, 4);

        // Test 6: back-to-back tile with signed data, started the cycle after done.
        tv[0] = vec(-1, 2, -3, 4);
        push_tile(1);
        n0 = act_cyc.size();
        start = 1'b1; rows = 8'd1; step(); start = 1'b0;
        in_valid = 1'b1; in_data = tv[0]; step();
        in_valid = 1'b0; in_data = '0;
        l0 = $signed(out_data[DW-1:0]);
        check("t6_lane0_signed", l0, -1);
        check("t6_active", out_active, 1);
        wait_done("t6_done");
        check("t6_active_cnt", act_cyc.size() - n0, 4);
        check("t6_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
